// File: rtl/param_read_cache.sv
// Read-only set-associative instruction cache with true LRU (per-line age counters),
// variable-latency word-by-word line fill, fill abort, invalidate-all and saturating stats.
module param_read_cache #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 2,
  parameter int NUM_WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_flush,
  input  logic              cpu_inval,
  output logic              cpu_hit,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic [1:0]        o_state
);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(NUM_WAYS - 1);

  // Handshake: mem_req is held with a stable mem_addr until a cycle with mem_rvalid=1,
  // which completes that beat; cpu_req is held with a stable cpu_addr until cpu_hit=1.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_INSTALL = 2'd2} state_e;
  state_e state_q, state_d;

  logic              valid_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]  age_q   [NUM_SETS][NUM_WAYS];
  logic [DATA_W-1:0] data_q  [NUM_SETS][NUM_WAYS][LINE_WORDS];
  logic [DATA_W-1:0] buf_q   [LINE_WORDS];

  logic [TAG_W-1:0]  fill_tag_q;
  logic [IDX_WS-1:0] fill_idx_q;
  logic [WAY_W-1:0]  victim_q;
  logic [OFF_W-1:0]  beat_q;
  logic [15:0]       hit_cnt_q, miss_cnt_q;

  logic [TAG_W-1:0]  cur_tag;
  logic [IDX_WS-1:0] cur_idx;
  logic [OFF_W-1:0]  cur_off;
  logic              any_hit, victim_found, start_fill, last_beat, install, touch_en;
  logic [WAY_W-1:0]  hit_way, victim, touch_way, old_age;
  logic [IDX_WS-1:0] touch_set;
  logic [WAY_W-1:0]  touch_age [NUM_WAYS];

  assign cur_tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cur_off = cpu_addr[OFF_W-1:0];

  if (IDX_W > 0) begin : g_idx
    assign cur_idx  = cpu_addr[OFF_W +: IDX_W];
    assign mem_addr = {fill_tag_q, fill_idx_q, beat_q};
  end else begin : g_noidx
    assign cur_idx  = '0;
    assign mem_addr = {fill_tag_q, beat_q};
  end

  always_comb begin
    any_hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[cur_idx][w] && (tag_q[cur_idx][w] == cur_tag)) begin
        any_hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Prefer the lowest invalid way; otherwise evict the oldest line of the set.
  always_comb begin
    victim       = '0;
    victim_found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!victim_found && !valid_q[cur_idx][w]) begin
        victim       = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[cur_idx][w] == AGE_MAX) victim = WAY_W'(w);
      end
    end
  end

  assign cpu_hit    = cpu_req && (state_q == S_IDLE) && any_hit && !cpu_inval;
  assign cpu_rdata  = cpu_hit ? data_q[cur_idx][hit_way][cur_off] : '0;
  assign start_fill = cpu_req && (state_q == S_IDLE) && !any_hit && !cpu_inval;
  assign last_beat  = mem_rvalid && (beat_q == OFF_W'(LINE_WORDS - 1));
  assign install    = (state_q == S_INSTALL) && !cpu_inval;

  // Touch keeps each set's ages a permutation: younger-than-touched ways age by one.
  always_comb begin
    touch_en  = cpu_hit || install;
    touch_set = install ? fill_idx_q : cur_idx;
    touch_way = install ? victim_q : hit_way;
    old_age   = age_q[touch_set][touch_way];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (WAY_W'(w) == touch_way)          touch_age[w] = '0;
      else if (age_q[touch_set][w] < old_age) touch_age[w] = age_q[touch_set][w] + 1'b1;
      else                                 touch_age[w] = age_q[touch_set][w];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cpu_inval) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (start_fill) state_d = S_FILL;
        S_FILL:    if (cpu_flush) state_d = S_IDLE;
                   else if (last_beat) state_d = S_INSTALL;
        S_INSTALL: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req  = (state_q == S_FILL);
    cpu_busy = (state_q != S_IDLE);
    o_state  = state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      victim_q   <= '0;
      beat_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (start_fill) begin
        fill_tag_q <= cur_tag;
        fill_idx_q <= cur_idx;
        victim_q   <= victim;
      end
      if (cpu_inval || cpu_flush || (state_q != S_FILL)) beat_q <= '0;
      else if (mem_rvalid)                              beat_q <= beat_q + 1'b1;
      if (cpu_hit && (hit_cnt_q != 16'hFFFF))     hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (start_fill && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
    end else if (cpu_inval) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
    end else begin
      if (install) valid_q[fill_idx_q][victim_q] <= 1'b1;
      if (touch_en) begin
        for (int w = 0; w < NUM_WAYS; w++) age_q[touch_set][w] <= touch_age[w];
      end
    end
  end

  // Payload storage needs no reset: it is only visible through a valid line.
  always_ff @(posedge clk) begin
    if ((state_q == S_FILL) && mem_rvalid) buf_q[beat_q] <= mem_rdata;
    if (install) begin
      tag_q[fill_idx_q][victim_q] <= fill_tag_q;
      for (int i = 0; i < LINE_WORDS; i++) data_q[fill_idx_q][victim_q][i] <= buf_q[i];
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_param_read_cache.sv
// Bench for param_read_cache: default 2x2x4 instance plus a 4-set/4-way/8-word instance,
// both fed by a memory responder that returns addr+16'hA000 with optional random stalls.
module tb_param_read_cache;
  logic clk;
  logic reset_n;
  logic [1:0]       req, flush, inval, rvalid;
  logic [1:0][15:0] addr, mdata;
  wire  [1:0]       hit, busy, mreq;
  wire  [1:0][15:0] rdata, maddr, hcnt, mcnt;
  wire  [1:0][1:0]  st;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] fill_base [2];
  int wcnt [2];
  int rbeat [2];

  logic        m_valid [2][4][4];
  logic [15:0] m_tag   [2][4][4];
  int          m_age   [2][4][4];
  int          m_hits  [2];
  int          m_miss  [2];

  param_read_cache #(.ADDR_W(16), .DATA_W(16), .LINE_WORDS(4), .NUM_SETS(2), .NUM_WAYS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .cpu_req(req[0]), .cpu_addr(addr[0]), .cpu_flush(flush[0]),
    .cpu_inval(inval[0]), .cpu_hit(hit[0]), .cpu_rdata(rdata[0]), .cpu_busy(busy[0]),
    .mem_req(mreq[0]), .mem_addr(maddr[0]), .mem_rdata(mdata[0]), .mem_rvalid(rvalid[0]),
    .hit_cnt(hcnt[0]), .miss_cnt(mcnt[0]), .o_state(st[0]));

  param_read_cache #(.ADDR_W(16), .DATA_W(16), .LINE_WORDS(8), .NUM_SETS(4), .NUM_WAYS(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .cpu_req(req[1]), .cpu_addr(addr[1]), .cpu_flush(flush[1]),
    .cpu_inval(inval[1]), .cpu_hit(hit[1]), .cpu_rdata(rdata[1]), .cpu_busy(busy[1]),
    .mem_req(mreq[1]), .mem_addr(maddr[1]), .mem_rdata(mdata[1]), .mem_rvalid(rvalid[1]),
    .hit_cnt(hcnt[1]), .miss_cnt(mcnt[1]), .o_state(st[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory responder: one beat per (stall+1) cycles while mem_req is high.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!mreq[k]) begin
        rvalid[k] = 1'b0;
        rbeat[k]  = 0;
      end else if (wcnt[k] == 0) begin
        check_eq("mem_addr", {16'd0, maddr[k]}, 32'(fill_base[k]) + 32'(rbeat[k]));
        rvalid[k] = 1'b1;
        mdata[k]  = maddr[k] + 16'hA000;
        rbeat[k]++;
        wcnt[k]   = $urandom_range((k == 1) ? 3 : 0, 0);
      end else begin
        rvalid[k] = 1'b0;
        wcnt[k]--;
      end
    end
  end

  function automatic int n_ways(input int sel);
    return (sel == 1) ? 4 : 2;
  endfunction

  function automatic int off_w(input int sel);
    return (sel == 1) ? 3 : 2;
  endfunction

  function automatic void model_inval(input int sel);
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[sel][s][w] = 1'b0;
        m_tag[sel][s][w]   = 16'd0;
        m_age[sel][s][w]   = w;
      end
  endfunction

  // Reference true-LRU model; returns whether the access hits.
  function automatic logic model_access(input int sel, input logic [15:0] a);
    int idx_w, s, way, old;
    logic [15:0] tg;
    logic h;
    idx_w = (sel == 1) ? 2 : 1;
    s     = int'(a >> off_w(sel)) & ((1 << idx_w) - 1);
    tg    = a >> (off_w(sel) + idx_w);
    h     = 1'b0;
    way   = -1;
    for (int w = 0; w < n_ways(sel); w++)
      if (m_valid[sel][s][w] && m_tag[sel][s][w] == tg) begin h = 1'b1; way = w; end
    if (!h) begin
      for (int w = n_ways(sel) - 1; w >= 0; w--)
        if (!m_valid[sel][s][w]) way = w;
      if (way < 0)
        for (int w = 0; w < n_ways(sel); w++)
          if (m_age[sel][s][w] == n_ways(sel) - 1) way = w;
      m_valid[sel][s][way] = 1'b1;
      m_tag[sel][s][way]   = tg;
      m_miss[sel]++;
    end
    old = m_age[sel][s][way];
    for (int w = 0; w < n_ways(sel); w++)
      if (w == way) m_age[sel][s][w] = 0;
      else if (m_age[sel][s][w] < old) m_age[sel][s][w]++;
    m_hits[sel]++;
    return h;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0; flush = '0; inval = '0; addr = '0;
    for (int k = 0; k < 2; k++) begin
      model_inval(k);
      m_hits[k] = 0;
      m_miss[k] = 0;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic fetch(input int sel, input logic [15:0] a, output logic first_hit);
    logic exp_h;
    int n;
    exp_h = model_access(sel, a);
    exp_q.push_back(a + 16'hA000);
    fill_base[sel] = a & ~16'((1 << off_w(sel)) - 1);
    @(negedge clk);
    req[sel]  = 1'b1;
    addr[sel] = a;
    #2;
    first_hit = hit[sel];
    check_eq("first_cycle_hit", {31'd0, hit[sel]}, {31'd0, exp_h});
    if (exp_h) check_eq("hit_no_mem_req", {31'd0, mreq[sel]}, 32'd0);
    n = 0;
    while (!hit[sel] && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (hit[sel]) begin
      check_eq("rdata", {16'd0, rdata[sel]}, {16'd0, exp_q.pop_front()});
      if (!exp_h && sel == 0) check_eq("miss_to_hit_cycles", n, 6);
    end else begin
      check_eq("hit_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    req[sel] = 1'b0;
  endtask

  task automatic check_counters(input int sel);
    check_eq("hit_cnt", {16'd0, hcnt[sel]}, m_hits[sel]);
    check_eq("miss_cnt", {16'd0, mcnt[sel]}, m_miss[sel]);
  endtask

  initial begin
    logic h;
    logic [15:0] a;
    reset_n = 1'b0;
    req = '0; flush = '0; inval = '0; addr = '0;
    wcnt[0] = 0; wcnt[1] = 0;
    fill_base[0] = '0; fill_base[1] = '0;
    do_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      check_eq("reset_state", {30'd0, st[k]}, 32'd0);
      check_eq("reset_mem_req", {31'd0, mreq[k]}, 32'd0);
      check_eq("reset_mem_addr", {16'd0, maddr[k]}, 32'd0);
      check_eq("reset_busy", {31'd0, busy[k]}, 32'd0);
      check_counters(k);
    end

    // Cold miss then hit in the same line.
    fetch(0, 16'h0012, h);
    check_eq("t1_miss_cnt", {16'd0, mcnt[0]}, 32'd1);
    fetch(0, 16'h0011, h);
    check_eq("t2_hit", {31'd0, h}, 32'd1);
    check_eq("t2_hit_cnt", {16'd0, hcnt[0]}, 32'd2);
    check_counters(0);

    // Invalidate with a hitting request in the same cycle: no hit reported.
    @(negedge clk);
    req[0] = 1'b1; addr[0] = 16'h0011; inval[0] = 1'b1;
    #2;
    check_eq("inval_blocks_hit", {31'd0, hit[0]}, 32'd0);
    @(negedge clk);
    req[0] = 1'b0; inval[0] = 1'b0;
    model_inval(0);
    fetch(0, 16'h0011, h);
    check_eq("t5_miss_after_inval", {31'd0, h}, 32'd0);
    check_counters(0);

    // LRU replacement in set 0 of the 2x2 cache.
    do_reset();
    fetch(0, 16'h0000, h);
    fetch(0, 16'h0008, h);
    fetch(0, 16'h0000, h);
    fetch(0, 16'h0010, h);
    fetch(0, 16'h0000, h);
    check_eq("t3_mru_kept", {31'd0, h}, 32'd1);
    fetch(0, 16'h0008, h);
    check_eq("t3_lru_evicted", {31'd0, h}, 32'd0);
    check_counters(0);

    // Flush after beat 1 of a fill.
    m_miss[0]++;
    fill_base[0] = 16'h0020;
    @(negedge clk);
    req[0] = 1'b1; addr[0] = 16'h0020;
    repeat (3) @(negedge clk);
    #2;
    check_eq("t4_in_fill", {30'd0, st[0]}, 32'd1);
    flush[0] = 1'b1; req[0] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t4_flush_mem_req", {31'd0, mreq[0]}, 32'd0);
    check_eq("t4_flush_state", {30'd0, st[0]}, 32'd0);
    @(negedge clk);
    flush[0] = 1'b0;
    fetch(0, 16'h0020, h);
    check_eq("t4_still_miss", {31'd0, h}, 32'd0);
    check_counters(0);

    // Invalidate coinciding with the last beat: nothing installed.
    m_miss[0]++;
    fill_base[0] = 16'h0024;
    @(negedge clk);
    req[0] = 1'b1; addr[0] = 16'h0024;
    repeat (4) @(negedge clk);
    inval[0] = 1'b1; req[0] = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_inval_state", {30'd0, st[0]}, 32'd0);
    check_eq("t5_inval_mem_req", {31'd0, mreq[0]}, 32'd0);
    @(negedge clk);
    inval[0] = 1'b0;
    model_inval(0);
    fetch(0, 16'h0024, h);
    check_eq("t5_no_install", {31'd0, h}, 32'd0);
    fetch(0, 16'h0020, h);
    check_counters(0);

    // Wide configuration: five tags thrash one set under random memory stalls.
    for (int i = 0; i < 40; i++) begin
      a = 16'(($urandom_range(5, 1) << 5) | (2 << 3) | $urandom_range(7, 0));
      fetch(1, a, h);
    end
    check_counters(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
